// File: rtl/urisc_mmio.sv
// urisc_mmio: 4-byte MMIO window on the urisc bus with a TX byte FIFO and an RX holding register.
// Define URISC_MMIO_LOOPBACK_EN to add CTRL.loopback, which routes the TX head into the RX register.
module urisc_mmio #(
    parameter logic [7:0]  BASE_ADDR = 8'hF0,
    parameter int unsigned TX_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    input  logic       we,
    output logic [7:0] data_out,
    output logic       hit,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);

    localparam int unsigned   PW       = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int unsigned   CW       = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(TX_DEPTH);

    localparam logic [1:0] OFF_TX     = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_RX     = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    logic [7:0]    mem_q [TX_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          drop_q, drop_d;
    logic [7:0]    rx_q, rx_d;
    logic          rxf_q, rxf_d;
    logic          loopback;

`ifdef URISC_MMIO_LOOPBACK_EN
    logic          lb_q, lb_d;
    assign loopback = lb_q;
`else
    assign loopback = 1'b0;
`endif

    logic       wr;
    logic       tx_ne;
    logic       tx_full;
    logic       lb_xfer;
    logic       tx_pop;
    logic       tx_push;
    logic       push_ok;
    logic       rx_load;
    logic [7:0] rx_src;

    assign hit     = (addr[7:2] == BASE_ADDR[7:2]);
    assign wr      = we && hit;
    assign tx_ne   = (count_q != '0);
    assign tx_full = (count_q == FULL_CNT);

    // In loopback the head moves internally whenever RX has room; external handshakes are masked.
    assign lb_xfer = loopback && tx_ne && !rxf_q;
    assign tx_pop  = loopback ? lb_xfer : (tx_ne && tx_ready);
    assign tx_push = wr && (addr[1:0] == OFF_TX);
    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign push_ok = tx_push && (!tx_full || tx_pop);
    assign rx_load = loopback ? lb_xfer : (rx_valid && !rxf_q);
    assign rx_src  = loopback ? mem_q[rptr_q] : rx_data;

    assign tx_data  = mem_q[rptr_q];
    assign tx_valid = tx_ne && !loopback;
    assign rx_ready = !rxf_q && !loopback;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        drop_d  = drop_q;
        rx_d    = rx_q;
        rxf_d   = rxf_q;

        if (push_ok) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (tx_pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(tx_pop);

        if (tx_push && !push_ok) begin
            drop_d = 1'b1;
        end else if (wr && (addr[1:0] == OFF_STATUS)) begin
            drop_d = 1'b0;
        end

        if (rx_load) begin
            rxf_d = 1'b1;
            rx_d  = rx_src;
        end else if (wr && (addr[1:0] == OFF_RX)) begin
            rxf_d = 1'b0;
        end
    end

`ifdef URISC_MMIO_LOOPBACK_EN
    always_comb begin
        lb_d = lb_q;
        if (wr && (addr[1:0] == OFF_CTRL)) begin
            lb_d = data_in[0];
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < TX_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
            rx_q    <= '0;
            rxf_q   <= 1'b0;
`ifdef URISC_MMIO_LOOPBACK_EN
            lb_q    <= 1'b0;
`endif
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= data_in;
            end
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            rx_q    <= rx_d;
            rxf_q   <= rxf_d;
`ifdef URISC_MMIO_LOOPBACK_EN
            lb_q    <= lb_d;
`endif
        end
    end

    // Reads are pure functions of addr and current state.
    always_comb begin
        data_out = '0;
        if (hit) begin
            unique case (addr[1:0])
                OFF_TX:     data_out = '0;
                OFF_STATUS: data_out = {3'b000, drop_q, rxf_q, !tx_ne, tx_full, 1'b0};
                OFF_RX:     data_out = rxf_q ? rx_q : '0;
`ifdef URISC_MMIO_LOOPBACK_EN
                OFF_CTRL:   data_out = {7'b0, lb_q};
`else
                OFF_CTRL:   data_out = '0;
`endif
                default:    data_out = '0;
            endcase
        end
    end

endmodule

// File: doc/urisc_mmio.md
Name: urisc_mmio

Overview:
Memory-mapped I/O responder on the 8-bit urisc memory bus. It sits beside the main memory and claims a 4-byte window. It gives subleq programs a byte output stream through a TX FIFO and a byte input stream through an RX holding register, both with valid/ready handshakes. Top level ORs `data_out` with the memory read data, qualified by `hit`.

Parameters:
BASE_ADDR, 8'hF0, base of the 4-byte register window; low two bits must be 0.
TX_DEPTH, 4, TX FIFO entries; power of 2, range 2..16.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
addr  in  8  bus address from urisc
data_in  in  8  bus write data from urisc
we  in  1  bus write strobe, sampled at posedge clk
data_out  out  8  read data; 0 when not hit
hit  out  1  addr[7:2] == BASE_ADDR[7:2], combinational
tx_data  out  8  head of TX FIFO
tx_valid  out  1  TX FIFO non-empty
tx_ready  in  1  consumer accepts tx_data when tx_valid && tx_ready
rx_data  in  8  incoming byte
rx_valid  in  1  incoming byte valid
rx_ready  out  1  RX holding register empty

Behaviour:
- Register map (offset = addr[1:0]):
  - 0 TX_DATA: write pushes data_in; read returns 0.
  - 1 STATUS: read {3'b0, tx_drop, rx_full, tx_empty, tx_full, 1'b0}. Any write clears tx_drop.
  - 2 RX_DATA: read returns held byte, or 0 if empty. Any write pops the holding register; a write when empty has no effect.
  - 3 CTRL: see optional feature; without it, reads 0 and ignores writes.
- Reads are combinational from addr and have no side effects, because subleq reads B before writing B. All side effects occur on writes at posedge clk with we && hit.
- Reset (reset low, async): FIFO pointers and count = 0, tx_drop = 0, rx_full = 0, CTRL = 0. Outputs: tx_valid = 0, rx_ready = 1, tx_data = 0. data_out and hit follow addr combinationally.
- TX FIFO:
  - count 0..TX_DEPTH.
  - pop when tx_valid && tx_ready; push on a TX_DATA write.
  - Push and pop in the same cycle: both take effect, count unchanged. This also applies when full.
  - Push when full with no pop: data discarded, tx_drop set (sticky).
  - tx_data is the registered head. It is valid the cycle after the push into an empty FIFO (1-cycle latency).
  - Pointers wrap modulo TX_DEPTH.
- RX holding register:
  - Loads rx_data when rx_valid && rx_ready.
  - rx_ready = !rx_full.
  - A pop (write to RX_DATA) and a load in the same cycle are impossible, since the load requires empty. A pop on full makes rx_ready high in the next cycle.
- Writes outside the window are ignored. data_out = 0 when !hit.
- Reset asserted mid-transfer discards all FIFO and RX contents immediately.

Optional Feature:
Macro URISC_MMIO_LOOPBACK_EN.
- Defined:
  - CTRL bit0 = loopback (read/write, reset 0). Other CTRL bits read 0.
  - With loopback=1: the TX FIFO head feeds the RX holding register internally. The internal transfer happens when tx_valid && !rx_full.
  - External tx_valid is forced 0 and tx_ready is ignored.
  - External rx_ready is forced 0 and rx_valid is ignored.
- Not defined: no loopback logic; CTRL is read-as-zero / write-ignored.

Test Plan:
- Reset low at t=0, released at 12: tx_valid=0, rx_ready=1, STATUS read (addr F1) = 8'h04, hit=1 for addr F0..F3, hit=0 and data_out=0 for addr EF.
- Write 8'h41, 8'h42 to F0 with tx_ready=0: tx_valid=1, tx_data=8'h41. Then tx_ready=1 for 2 cycles: emits 41 then 42, then tx_valid=0 and STATUS bit2=1.
- TX_DEPTH=4, tx_ready=0, write 5 bytes (1..5): STATUS = 8'h12 (full, drop). Drain yields 1,2,3,4. Write any value to F1: tx_drop=0.
- Full FIFO with tx_ready=1 and a simultaneous push of 8'h09: count stays 4, no drop, 8'h09 is emitted last.
- rx_valid=1, rx_data=8'hFE: rx_ready drops, read F2 = 8'hFE (signed -2), STATUS bit3=1. Write F2: rx_ready=1 next cycle, read F2 = 0.
- With URISC_MMIO_LOOPBACK_EN: write 1 to F3, write 8'h33 to F0: within 2 cycles read F2 = 8'h33 and tx_valid stays 0 throughout. Assert reset mid-run: all state cleared and CTRL reads 0.
